// File: rtl/booth_multiplier_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, Booth digits
// and the triplet recoder.
package booth_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_e;

  // Triplet is {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_digit_e booth_recode(input logic [2:0] triplet);
    booth_digit_e digit;
    case (triplet)
      3'b001, 3'b010: digit = POS1;
      3'b011:         digit = POS2;
      3'b100:         digit = NEG2;
      3'b101, 3'b110: digit = NEG1;
      default:        digit = ZERO;
    endcase
    return digit;
  endfunction

endpackage

// File: rtl/booth_multiplier_datapath.sv
// Operand/accumulator registers, Booth recoder, adder/subtractor and
// arithmetic right shift; sequenced by the controller in the top level.
module booth_multiplier_datapath
  import booth_multiplier_pkg::*;
#(
  parameter int size = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic                step_i,
  input  logic                write_i,
  input  logic                signed_i,
  input  logic [size-1:0]     a_i,
  input  logic [size-1:0]     b_i,
  output logic [2*size-1:0]   s_o
);

  // W: extended operand width; HW: accumulator high part with headroom for +/-2A.
  localparam int W  = size + 2;
  localparam int HW = W + 2;
  localparam int AW = HW + W;

  logic signed [W-1:0]    a_q, a_d;
  logic signed [HW-1:0]   hi_q, hi_d;
  logic [W-1:0]           lo_q, lo_d;
  logic                   bprev_q, bprev_d;
  logic [2*size-1:0]      s_q, s_d;

  logic [W-1:0]           a_ext;
  logic [W-1:0]           b_ext;
  logic [2:0]             triplet;
  booth_digit_e           digit;
  logic signed [HW-1:0]   a_wide;
  logic signed [HW-1:0]   addend;
  logic signed [HW-1:0]   sum_hi;
  logic signed [AW-1:0]   acc_sum;
  logic signed [AW-1:0]   acc_next;

  always_comb begin
    a_ext   = signed_i ? {{2{a_i[size-1]}}, a_i} : {2'b00, a_i};
    b_ext   = signed_i ? {{2{b_i[size-1]}}, b_i} : {2'b00, b_i};

    triplet = {lo_q[1:0], bprev_q};
    digit   = booth_recode(triplet);
    a_wide  = {{2{a_q[W-1]}}, a_q};

    case (digit)
      POS1:    addend = a_wide;
      POS2:    addend = a_wide <<< 1;
      NEG1:    addend = -a_wide;
      NEG2:    addend = -(a_wide <<< 1);
      default: addend = '0;
    endcase

    sum_hi   = hi_q + addend;
    acc_sum  = {sum_hi, lo_q};
    acc_next = acc_sum >>> 2;

    a_d     = a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    bprev_d = bprev_q;
    s_d     = s_q;

    if (load_i) begin
      a_d     = a_ext;
      hi_d    = '0;
      lo_d    = b_ext;
      bprev_d = 1'b0;
    end else if (step_i) begin
      hi_d    = acc_next[AW-1:W];
      lo_d    = acc_next[W-1:0];
      bprev_d = lo_q[1];
    end

    // The final iteration's result goes straight to S on the same edge.
    if (write_i) begin
      s_d = acc_next[2*size-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      bprev_q <= 1'b0;
      s_q     <= '0;
    end else begin
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      bprev_q <= bprev_d;
      s_q     <= s_d;
    end
  end

  assign s_o = s_q;

endmodule

// File: rtl/booth_multiplier.sv
// Radix-4 Booth sequential multiplier: IDLE/CALC/DONE controller and
// iteration counter around the arithmetic datapath.
module booth_multiplier
  import booth_multiplier_pkg::*;
#(
  parameter int size = 8
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                START,
  input  logic                SIGNED,
  input  logic [size-1:0]     A,
  input  logic [size-1:0]     B,
  output logic [2*size-1:0]   S,
  output logic                BUSY,
  output logic                END_MULT
);

  localparam int N     = size / 2 + 1;
  localparam int CNT_W = $clog2(N);

  if ((size % 2) != 0 || size < 4) begin : g_bad_size
    $error("booth_multiplier: size must be even and at least 4");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               load;
  logic               step;
  logic               write_s;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    write_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (START) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        step  = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          write_s = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign BUSY     = (state_q != IDLE);
  assign END_MULT = (state_q == DONE);

  booth_multiplier_datapath #(
    .size (size)
  ) u_datapath (
    .clk_i    (CLOCK),
    .rst_i    (RESET),
    .load_i   (load),
    .step_i   (step),
    .write_i  (write_s),
    .signed_i (SIGNED),
    .a_i      (A),
    .b_i      (B),
    .s_o      (S)
  );

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier at size=8 and size=16 against an
// integer-arithmetic product model.
module tb_booth_multiplier;

  logic        clk = 1'b0;
  logic        rst;

  logic        start8, sg8;
  logic [7:0]  a8, b8;
  logic [15:0] s8;
  logic        busy8, end8;

  logic        start16, sg16;
  logic [15:0] a16, b16;
  logic [31:0] s16;
  logic        busy16, end16;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  booth_multiplier #(.size(8)) u_dut8 (
    .CLOCK(clk), .RESET(rst), .START(start8), .SIGNED(sg8),
    .A(a8), .B(b8), .S(s8), .BUSY(busy8), .END_MULT(end8)
  );

  booth_multiplier #(.size(16)) u_dut16 (
    .CLOCK(clk), .RESET(rst), .START(start16), .SIGNED(sg16),
    .A(a16), .B(b16), .S(s16), .BUSY(busy16), .END_MULT(end16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input bit w16, input bit sg,
                                          input logic [15:0] a, input logic [15:0] b);
    longint sa, sb, p;
    if (w16) begin
      if (sg) begin sa = longint'($signed(a)); sb = longint'($signed(b)); end
      else    begin sa = longint'(a);          sb = longint'(b);          end
    end else begin
      if (sg) begin sa = longint'($signed(a[7:0])); sb = longint'($signed(b[7:0])); end
      else    begin sa = longint'(a[7:0]);          sb = longint'(b[7:0]);          end
    end
    p = sa * sb;
    return w16 ? p[31:0] : {16'h0, p[15:0]};
  endfunction

  // One START handshake; inputs are scrambled after capture to prove isolation.
  task automatic op(input bit w16, input bit sg, input logic [15:0] a, input logic [15:0] b,
                    input logic [31:0] exp, input string tag, input bit timing);
    int lat, bcnt, n;
    n = w16 ? 9 : 5;
    @(negedge clk);
    if (w16) begin start16 = 1'b1; sg16 = sg; a16 = a; b16 = b; end
    else begin start8 = 1'b1; sg8 = sg; a8 = a[7:0]; b8 = b[7:0]; end
    @(posedge clk);
    @(negedge clk);
    start8  = 1'b0;
    start16 = 1'b0;
    if (w16) begin a16 = ~a; b16 = a ^ b; sg16 = ~sg; end
    else begin a8 = ~a[7:0]; b8 = a[7:0] ^ b[7:0]; sg8 = ~sg; end
    bcnt = (w16 ? busy16 : busy8) ? 1 : 0;
    lat  = 0;
    while (!(w16 ? end16 : end8) && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      bcnt += (w16 ? busy16 : busy8) ? 1 : 0;
    end
    chk({tag, " S"}, w16 ? s16 : {16'h0, s8}, exp);
    if (timing) begin
      chk({tag, " latency"}, 32'(lat), 32'(n));
      chk({tag, " busy cycles"}, 32'(bcnt), 32'(n + 1));
      @(posedge clk);
      @(negedge clk);
      chk({tag, " END_MULT width"}, {31'h0, (w16 ? end16 : end8)}, 32'h0);
      chk({tag, " BUSY after"}, {31'h0, (w16 ? busy16 : busy8)}, 32'h0);
    end
  endtask

  initial begin
    int pulses, last, stray;
    logic [31:0] s_at;
    logic [15:0] prev, ra, rb;
    logic        rs;

    rst = 1'b1;
    start8 = 1'b0; sg8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; sg16 = 1'b0; a16 = '0; b16 = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset S8", {16'h0, s8}, 32'h0);
    chk("reset BUSY8", {31'h0, busy8}, 32'h0);
    chk("reset END8", {31'h0, end8}, 32'h0);
    chk("reset S16", s16, 32'h0);
    chk("reset BUSY16", {31'h0, busy16}, 32'h0);
    chk("reset END16", {31'h0, end16}, 32'h0);
    rst = 1'b0;

    op(1'b0, 1'b0, 16'h00FF, 16'h00FF, 32'h0000_FE01, "u8 FFxFF", 1'b1);
    op(1'b0, 1'b1, 16'h0080, 16'h0080, 32'h0000_4000, "s8 80x80", 1'b1);
    op(1'b0, 1'b1, 16'h0080, 16'h007F, 32'h0000_C080, "s8 80x7F", 1'b1);
    op(1'b0, 1'b1, 16'h00FF, 16'h0001, 32'h0000_FFFF, "s8 FFx01", 1'b1);
    op(1'b0, 1'b0, 16'h00FF, 16'h0001, 32'h0000_00FF, "u8 FFx01", 1'b1);
    op(1'b1, 1'b0, 16'h8000, 16'h8000, 32'h4000_0000, "u16 8000x8000", 1'b1);
    op(1'b1, 1'b1, 16'h8000, 16'h8000, 32'h4000_0000, "s16 8000x8000", 1'b1);

    // START re-pulsed during CALC with new operands and mode must be ignored
    @(negedge clk);
    start8 = 1'b1; sg8 = 1'b0; a8 = 8'd3; b8 = 8'd5;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd7; b8 = 8'd7; sg8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    pulses = 0;
    s_at   = '0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (end8) begin pulses++; s_at = {16'h0, s8}; end
    end
    chk("ignore START pulses", 32'(pulses), 32'd1);
    chk("ignore START S", s_at, 32'h0000_000F);
    chk("ignore START idle", {31'h0, busy8}, 32'h0);

    // Reset two cycles into CALC aborts the operation
    @(negedge clk);
    start8 = 1'b1; sg8 = 1'b0; a8 = 8'h55; b8 = 8'h66;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort S", {16'h0, s8}, 32'h0);
    chk("abort BUSY", {31'h0, busy8}, 32'h0);
    chk("abort END", {31'h0, end8}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (end8) pulses++;
    end
    chk("abort no END", 32'(pulses), 32'd0);
    op(1'b0, 1'b0, 16'h0012, 16'h0034, 32'h0000_03A8, "post-reset", 1'b1);

    // START held high for 20 cycles
    @(negedge clk);
    a8 = 8'd9; b8 = 8'd11; sg8 = 1'b0; start8 = 1'b1;
    prev = s8; last = -1; pulses = 0; stray = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (end8) begin
        pulses++;
        chk("held S", {16'h0, s8}, 32'h0000_0063);
        if (last >= 0) chk("held interval", 32'(c - last), 32'd7);
        last = c;
      end else if (s8 !== prev) begin
        stray++;
      end
      prev = s8;
    end
    start8 = 1'b0;
    chk("held pulses", 32'(pulses), 32'd3);
    chk("held stray S updates", 32'(stray), 32'd0);
    @(negedge clk);
    chk("held drain", {31'h0, busy8}, 32'h0);

    for (int i = 0; i < 1500; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom_range(0, 1));
      op(1'b0, rs, ra, rb, ref_mul(1'b0, rs, ra, rb), "rand8", 1'b0);
    end
    for (int i = 0; i < 2500; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom_range(0, 1));
      op(1'b1, rs, ra, rb, ref_mul(1'b1, rs, ra, rb), "rand16", 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
